// File: rtl/pycpu_bus_pkg.sv
// Shared constants for the pycpu external bus: data width, read/write encoding
// and the memory responder's state encoding.
package pycpu_bus_pkg;

   localparam int BUS_W = 16;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

endpackage

// File: rtl/bus_mem_array.sv
// Single-port synchronous word RAM behind the bus responder; read data is
// registered and reflects the addressed word as it was before any same-edge write.
module bus_mem_array #(
   parameter int DEPTH = 256,
   parameter int AW    = 8,
   parameter int DW    = 16
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side responder of the CPU external bus with programmable wait states.
// Define BUS_MEM_FAULT_INT_EN to add the out-of-range fault interrupt and sticky fault address.
module bus_mem_responder
   import pycpu_bus_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int AW          = 8,
   parameter int WAIT_STATES = 2
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             i_req,
   input  logic             i_rw,
   input  logic [BUS_W-1:0] i_addr,
   input  logic [BUS_W-1:0] i_data,
   output logic [BUS_W-1:0] o_data,
   output logic             o_data_oe,
   output logic             o_lock,
   output logic             o_ack
`ifdef BUS_MEM_FAULT_INT_EN
   ,
   output logic             o_fault_int
`endif
);

   logic [1:0]       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [BUS_W-1:0] addr_q, addr_d;
   logic [BUS_W-1:0] wdata_q, wdata_d;
   logic [BUS_W-1:0] odata_q, odata_d;
   logic             rw_q, rw_d;
   logic             lock_q, lock_d;
   logic             ack_q, ack_d;
   logic             oe_q, oe_d;

   logic             outOfRange;
   logic             memWe;
   logic [BUS_W-1:0] memRdata;
   logic [BUS_W-1:0] readValue;
   logic             respRead;

   assign outOfRange = (32'(addr_q) >= DEPTH);
   assign memWe      = (state_q == ST_ACCESS) && (rw_q == RW_WRITE) && !outOfRange;
   assign readValue  = outOfRange ? '0 : memRdata;
   assign respRead   = (state_q == ST_RESP) && (rw_q == RW_READ);

   bus_mem_array #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (BUS_W)
   ) u_array (
      .clk   (clk),
      .we    (memWe),
      .addr  (addr_q[AW-1:0]),
      .wdata (wdata_q),
      .rdata (memRdata)
   );

   // The RAM output lands in the RESP cycle, so read data is forwarded live there
   // and captured on leaving RESP so that it holds afterwards.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rw_d    = rw_q;
      odata_d = odata_q;
      lock_d  = lock_q;
      ack_d   = 1'b0;
      oe_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_req) begin
               addr_d  = i_addr;
               rw_d    = i_rw;
               wdata_d = i_data;
               lock_d  = 1'b1;
               if (WAIT_STATES > 0) begin
                  state_d = ST_WAIT;
                  cnt_d   = 4'(WAIT_STATES - 1);
               end else begin
                  state_d = ST_ACCESS;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_ACCESS;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_ACCESS: begin
            state_d = ST_RESP;
            lock_d  = 1'b0;
            ack_d   = 1'b1;
            oe_d    = (rw_q == RW_READ);
         end
         default: begin
            state_d = ST_IDLE;
            if (rw_q == RW_READ) begin
               odata_d = readValue;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rw_q    <= RW_READ;
         odata_q <= '0;
         lock_q  <= 1'b0;
         ack_q   <= 1'b0;
         oe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rw_q    <= rw_d;
         odata_q <= odata_d;
         lock_q  <= lock_d;
         ack_q   <= ack_d;
         oe_q    <= oe_d;
      end
   end

   assign o_data    = respRead ? readValue : odata_q;
   assign o_data_oe = oe_q;
   assign o_lock    = lock_q;
   assign o_ack     = ack_q;

`ifdef BUS_MEM_FAULT_INT_EN
   logic             faultInt_q;
   logic [BUS_W-1:0] fault_addr_q;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         faultInt_q   <= 1'b0;
         fault_addr_q <= '0;
      end else begin
         faultInt_q <= (state_q == ST_ACCESS) && outOfRange;
         if ((state_q == ST_ACCESS) && outOfRange) begin
            fault_addr_q <= addr_q;
         end
      end
   end

   assign o_fault_int = faultInt_q;
`endif

endmodule

// File: tb/tb_bus_mem_responder.sv
// Self-checking bench for bus_mem_responder: one instance with two wait states and
// one with none, checked against a word-array reference model of the memory.
module tb_bus_mem_responder;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        req   [2];
   logic        rw    [2];
   logic [15:0] addr  [2];
   logic [15:0] wdata [2];
   logic [15:0] rdata [2];
   logic        oe    [2];
   logic        lock  [2];
   logic        ack   [2];
`ifdef BUS_MEM_FAULT_INT_EN
   logic        fint  [2];
`endif

   int testsRun    = 0;
   int testsFailed = 0;

   logic [15:0] refMem    [2][256];
   bit          refKnown  [2][256];
   logic [15:0] held      [2];
   bit          heldKnown [2];
   time         accTime   [2];

   always #5 clk = ~clk;

   bus_mem_responder #(.DEPTH(256), .AW(8), .WAIT_STATES(0)) u_dut0 (
      .clk       (clk),
      .n_rst     (n_rst),
      .i_req     (req[0]),
      .i_rw      (rw[0]),
      .i_addr    (addr[0]),
      .i_data    (wdata[0]),
      .o_data    (rdata[0]),
      .o_data_oe (oe[0]),
      .o_lock    (lock[0]),
      .o_ack     (ack[0])
`ifdef BUS_MEM_FAULT_INT_EN
      ,
      .o_fault_int (fint[0])
`endif
   );

   bus_mem_responder #(.DEPTH(256), .AW(8), .WAIT_STATES(2)) u_dut1 (
      .clk       (clk),
      .n_rst     (n_rst),
      .i_req     (req[1]),
      .i_rw      (rw[1]),
      .i_addr    (addr[1]),
      .i_data    (wdata[1]),
      .o_data    (rdata[1]),
      .o_data_oe (oe[1]),
      .o_lock    (lock[1]),
      .o_ack     (ack[1])
`ifdef BUS_MEM_FAULT_INT_EN
      ,
      .o_fault_int (fint[1])
`endif
   );

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, actual, expected, $time);
      end
   endtask

   // One complete bus transaction on instance w, starting and ending at a falling edge.
   task automatic applyStimulus(input int w, input logic wr, input logic [15:0] a,
                                input logic [15:0] d, input bit holdReq);
      int          ws;
      int          k;
      bit          seenAck;
      bit          oorAcc;
      logic [15:0] expData;
      bit          expKnown;
      ws       = (w == 0) ? 0 : 2;
      oorAcc   = (a >= 16'd256);
      expData  = 16'h0000;
      expKnown = 1'b1;
      if (!wr && !oorAcc) begin
         expData  = refMem[w][a[7:0]];
         expKnown = refKnown[w][a[7:0]];
      end
      req[w]   = 1'b1;
      rw[w]    = wr;
      addr[w]  = a;
      wdata[w] = d;
      @(posedge clk);
      accTime[w] = $time;
      seenAck = 1'b0;
      k = 0;
      while (!seenAck && k < ws + 6) begin
         @(negedge clk);
         k++;
         if (ack[w]) begin
            seenAck = 1'b1;
            checkOutput("ackLatency", k, ws + 2);
            checkOutput("lockInResp", lock[w], 1'b0);
            checkOutput("oeInResp", oe[w], !wr);
            if (!wr && expKnown) begin
               checkOutput("readData", rdata[w], expData);
            end
`ifdef BUS_MEM_FAULT_INT_EN
            checkOutput("faultIntPulse", fint[w], oorAcc);
`endif
         end else begin
            if (k <= ws + 1) begin
               checkOutput("lockBusy", lock[w], 1'b1);
            end
            if (wr) begin
               checkOutput("oeOnWrite", oe[w], 1'b0);
            end
         end
         if (holdReq && !seenAck) begin
            req[w] = 1'b1;
         end else begin
            req[w] = 1'b0;
         end
         rw[w]    = 1'($urandom);
         addr[w]  = 16'($urandom);
         wdata[w] = 16'($urandom);
      end
      if (!seenAck) begin
         checkOutput("ackTimeout", 0, 1);
      end
      if (wr && !oorAcc) begin
         refMem[w][a[7:0]]   = d;
         refKnown[w][a[7:0]] = 1'b1;
      end
      if (!wr) begin
         held[w]      = expData;
         heldKnown[w] = expKnown;
      end
      req[w] = 1'b0;
      @(negedge clk);
      checkOutput("ackDrops", ack[w], 1'b0);
      checkOutput("oeDrops", oe[w], 1'b0);
      checkOutput("lockIdle", lock[w], 1'b0);
      if (heldKnown[w]) begin
         checkOutput("dataHolds", rdata[w], held[w]);
      end
`ifdef BUS_MEM_FAULT_INT_EN
      checkOutput("faultIntDrops", fint[w], 1'b0);
`endif
   endtask

   initial begin
      time         prevT;
      logic        wr;
      logic [15:0] a;
      for (int w = 0; w < 2; w++) begin
         req[w] = 1'b0; rw[w] = 1'b0; addr[w] = '0; wdata[w] = '0;
         held[w] = 16'h0000; heldKnown[w] = 1'b1; accTime[w] = 0;
         for (int i = 0; i < 256; i++) begin
            refMem[w][i] = 16'h0000; refKnown[w][i] = 1'b0;
         end
      end
      n_rst = 1'b0;
      #1;
      for (int w = 0; w < 2; w++) begin
         checkOutput("resetData", rdata[w], 16'h0000);
         checkOutput("resetOe", oe[w], 1'b0);
         checkOutput("resetLock", lock[w], 1'b0);
         checkOutput("resetAck", ack[w], 1'b0);
      end
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
      @(negedge clk);

      applyStimulus(1, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
      applyStimulus(1, 1'b0, 16'h0010, 16'h0000, 1'b0);

      applyStimulus(0, 1'b1, 16'h0000, 16'h1234, 1'b0);
      applyStimulus(0, 1'b0, 16'h0000, 16'h0000, 1'b0);

      applyStimulus(1, 1'b1, 16'h0000, 16'h7777, 1'b0);
      applyStimulus(1, 1'b1, 16'h0100, 16'hAAAA, 1'b0);
`ifdef BUS_MEM_FAULT_INT_EN
      checkOutput("faultAddr", u_dut1.fault_addr_q, 16'h0100);
`endif
      applyStimulus(1, 1'b0, 16'h0000, 16'h0000, 1'b0);
      applyStimulus(1, 1'b0, 16'h0100, 16'h0000, 1'b0);

      applyStimulus(1, 1'b0, 16'h0010, 16'h0000, 1'b1);
      applyStimulus(1, 1'b1, 16'h0030, 16'hC0DE, 1'b1);
      applyStimulus(1, 1'b0, 16'h0030, 16'h0000, 1'b0);

      // Abort a write while it is still waiting.
      applyStimulus(1, 1'b1, 16'h0020, 16'h1111, 1'b0);
      req[1] = 1'b1; rw[1] = 1'b1; addr[1] = 16'h0020; wdata[1] = 16'h5555;
      @(posedge clk);
      @(negedge clk);
      req[1] = 1'b0;
      checkOutput("midLockBusy", lock[1], 1'b1);
      n_rst = 1'b0;
      #1;
      checkOutput("midResetLock", lock[1], 1'b0);
      checkOutput("midResetAck", ack[1], 1'b0);
      checkOutput("midResetOe", oe[1], 1'b0);
      checkOutput("midResetData", rdata[1], 16'h0000);
      @(negedge clk);
      n_rst = 1'b1;
      held[0] = 16'h0000; heldKnown[0] = 1'b1;
      held[1] = 16'h0000; heldKnown[1] = 1'b1;
      @(negedge clk);
      applyStimulus(1, 1'b0, 16'h0020, 16'h0000, 1'b0);

      for (int i = 0; i < 8; i++) begin
         wr = (i % 2 == 0);
         a  = 16'($urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) begin
            a = a | 16'h0100;
         end
         prevT = accTime[1];
         applyStimulus(1, wr, a, 16'($urandom), 1'b0);
         if (i > 0) begin
            checkOutput("b2bSpacing", 32'((accTime[1] - prevT) / 10), 32'd5);
         end
      end

      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 1'($urandom), 16'($urandom_range(0, 7)), 16'($urandom), 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
- Responder (memory-side) end of the CPU external bus.
- Accepts a read or write from the CPU, inserts programmable wait states, and performs the access on an internal 16-bit word memory.
- Holds the bus lock while busy, drives read data back, and pulses an acknowledge.
- Sits outside the CPU top and connects to its o_addr / io_data / o_rw / io_lock pins through board-level tristate glue.

Parameters:
- DEPTH, 256, number of 16-bit words; legal addresses 0..DEPTH-1.
- AW, 8, internal address width, equal to clog2(DEPTH).
- WAIT_STATES, 2, extra cycles between accept and access; range 0..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- n_rst  input  1  asynchronous active-low reset.
- i_req  input  1  bus cycle request from the initiator.
- i_rw  input  1  0 = read, 1 = write (bus-wide convention).
- i_addr  input  16  word address.
- i_data  input  16  write data from the bus.
- o_data  output  16  read data.
- o_data_oe  output  1  high = responder drives io_data.
- o_lock  output  1  busy; initiator stalls while high.
- o_ack  output  1  one-cycle completion pulse.

Behaviour:
- Reset values: state IDLE; o_data=16'h0000, o_data_oe=0, o_lock=0, o_ack=0, wait counter=0. Memory contents are not reset.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - On an edge with i_req=1, latch i_addr, i_rw and i_data, and set o_lock=1.
  - Go to WAIT with the counter loaded to WAIT_STATES-1 if WAIT_STATES>0; otherwise go directly to ACCESS.
- WAIT:
  - Decrement the counter; when it is 0, go to ACCESS.
  - o_lock stays 1.
  - i_req and bus inputs are ignored; only the latched values are used.
- ACCESS:
  - Write: mem[addr] <= latched data.
  - Read: o_data <= mem[addr].
  - Go to RESP; o_lock stays 1.
- RESP:
  - o_lock=0, o_ack=1.
  - o_data_oe=1 only if the access is a read.
  - Next state is always IDLE.
  - On leaving RESP, o_ack and o_data_oe return to 0; o_data holds its value.
- Latency: from the accept edge to the o_ack cycle is WAIT_STATES+2 cycles.
- Back-to-back requests: i_req is sampled only in IDLE. The initiator drops i_req no later than the edge that ends o_ack. Minimum spacing between accepts is WAIT_STATES+3 cycles.
- Out of range (i_addr >= DEPTH, upper bits nonzero):
  - Read returns 16'h0000.
  - Write is dropped; memory is unchanged.
  - Handshake timing is identical to an in-range access.
- Reset mid-operation: immediately go to IDLE with all outputs at reset values. The pending write is not performed.
- Simultaneous events: i_req in WAIT, ACCESS or RESP has no effect and is not queued.
- Never drive o_data_oe=1 while the latched access is a write (avoids bus contention).

Optional Feature:
- Macro: BUS_MEM_FAULT_INT_EN.
- With the macro defined:
  - Add output o_fault_int (1 bit, reset 0), wired to the CPU's i_intb.
  - o_fault_int pulses high for exactly the RESP cycle of any out-of-range access.
  - Add a sticky 16-bit fault address register, reset 0, observable via hierarchical path for verification.
- Without the macro: no port and no register. Out-of-range accesses are silent as specified above.

Decomposition:
- Shared package pycpu_bus_pkg:
  - BUS_W=16.
  - RW_READ=1'b0, RW_WRITE=1'b1.
  - Responder state encoding (IDLE=2'd0, WAIT=2'd1, ACCESS=2'd2, RESP=2'd3).
- Sub-module bus_mem_array: single-port synchronous RAM (DEPTH x 16), with ports clk, we, addr, wdata, rdata registered. The FSM and handshake stay in bus_mem_responder.

Test Plan:
- Write then read, WAIT_STATES=2:
  - Write 16'hBEEF to 0x0010 -> o_lock high for 3 cycles, o_ack at accept+4, o_data_oe=0.
  - Read 0x0010 -> o_data=16'hBEEF with o_data_oe=1 in the o_ack cycle.
- WAIT_STATES=0: read 0x0000 after a write of 16'h1234 -> o_ack at accept+2 with o_data=16'h1234.
- Out of range:
  - Write 16'hAAAA to 0x0100 (DEPTH=256) -> o_ack normal, mem[0x00] unchanged.
  - Read 0x0100 -> 16'h0000.
  - With BUS_MEM_FAULT_INT_EN defined, o_fault_int pulses once and the fault register = 16'h0100.
- Requests while busy: hold i_req=1 continuously with varying i_addr during WAIT -> the latched address is used, and exactly one access completes per accept.
- Reset mid-operation: assert n_rst low during WAIT of a write of 16'h5555 to 0x0020 -> outputs reset asynchronously and mem[0x20] keeps its old value.
- Back-to-back: alternating read/write stream of 8 transactions -> o_data_oe is never high on a write and accept spacing is WAIT_STATES+3.
